// File: rtl/bist_misr_compactor_if.sv
// Handshake and result bundle between the pattern source and the MISR compactor.
// The master drives the run request, words and golden value; the slave returns status and signature.
interface bist_misr_compactor_if #(
    parameter int WIDTH      = 4,
    parameter int N_PATTERNS = 15
);
    localparam int CW = $clog2(N_PATTERNS + 1);

    logic             start;
    logic             pat_valid;
    logic [WIDTH-1:0] pat_data;
    logic [WIDTH-1:0] golden;
    logic             pat_ready;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;
    logic [CW-1:0]    pat_count;

    modport master (
        output start, pat_valid, pat_data, golden,
        input  pat_ready, busy, done, pass, signature, pat_count
    );

    modport slave (
        input  start, pat_valid, pat_data, golden,
        output pat_ready, busy, done, pass, signature, pat_count
    );
endinterface

// File: rtl/bist_misr_compactor.sv
// MISR response compactor: folds N_PATTERNS words into a signature after a start pulse,
// then reports done and whether the final signature matches the golden value.
module bist_misr_compactor #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] POLY       = 4'b0011,
    parameter logic [WIDTH-1:0] SEED       = 4'h0,
    parameter int               N_PATTERNS = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bist_misr_compactor_if.slave  bus
);
    localparam int CW = $clog2(N_PATTERNS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sig;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic [WIDTH-1:0] w_sigNext;
    logic             w_last;

    // Shift left, fold the outgoing msb back through the taps, then mix in the new word.
    assign w_sigNext = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ bus.pat_data;
    assign w_last    = (r_count == CW'(N_PATTERNS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sig   <= SEED;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        r_state <= RUN;
                        r_sig   <= SEED;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end
                end
                RUN: begin
                    // The verdict is latched on the edge that absorbs the final word.
                    if (bus.pat_valid) begin
                        r_sig   <= w_sigNext;
                        r_count <= r_count + CW'(1);
                        if (w_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_sigNext == bus.golden);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.pat_ready = r_busy;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.signature = r_sig;
    assign bus.pat_count = r_count;
endmodule

// File: tb/tb_bist_misr_compactor.sv
// Self-checking bench: three compactors (3, 2 and 15 words per run) share one stimulus
// stream and are compared every cycle against a polynomial-arithmetic reference model.
module tb_bist_misr_compactor;
    logic       clk;
    logic       rst_n;
    logic       tbStart;
    logic       tbValid;
    logic [3:0] tbData;
    logic [3:0] golden [3];

    int         nChecks;
    int         nFails;

    int         nPat [3] = '{3, 2, 15};
    int         mSig [3];
    int         mCnt [3];
    bit         mRun [3];
    bit         mDone [3];
    bit         mPass [3];

    bist_misr_compactor_if #(.WIDTH(4), .N_PATTERNS(3))  bus0 ();
    bist_misr_compactor_if #(.WIDTH(4), .N_PATTERNS(2))  bus1 ();
    bist_misr_compactor_if #(.WIDTH(4), .N_PATTERNS(15)) bus2 ();

    assign bus0.start     = tbStart;
    assign bus0.pat_valid = tbValid;
    assign bus0.pat_data  = tbData;
    assign bus0.golden    = golden[0];
    assign bus1.start     = tbStart;
    assign bus1.pat_valid = tbValid;
    assign bus1.pat_data  = tbData;
    assign bus1.golden    = golden[1];
    assign bus2.start     = tbStart;
    assign bus2.pat_valid = tbValid;
    assign bus2.pat_data  = tbData;
    assign bus2.golden    = golden[2];

    bist_misr_compactor #(.WIDTH(4), .POLY(4'b0011), .SEED(4'h0), .N_PATTERNS(3)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );
    bist_misr_compactor #(.WIDTH(4), .POLY(4'b0011), .SEED(4'h0), .N_PATTERNS(2)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );
    bist_misr_compactor #(.WIDTH(4), .POLY(4'b0011), .SEED(4'h0), .N_PATTERNS(15)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signature times x modulo x^4+x+1 over GF(2), plus the incoming word.
    function automatic int misrNext(input int s, input int d);
        int t;
        t = s * 2;
        if (t >= 16) t = t ^ 'h13;
        return t ^ d;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            mSig[i]  = 0;
            mCnt[i]  = 0;
            mRun[i]  = 1'b0;
            mDone[i] = 1'b0;
            mPass[i] = 1'b0;
        end
    endtask

    task automatic modelStep(input int i);
        if (!mRun[i]) begin
            if (tbStart) begin
                mRun[i]  = 1'b1;
                mDone[i] = 1'b0;
                mPass[i] = 1'b0;
                mSig[i]  = 0;
                mCnt[i]  = 0;
            end
        end else if (tbValid) begin
            mSig[i] = misrNext(mSig[i], int'(tbData));
            mCnt[i] = mCnt[i] + 1;
            if (mCnt[i] == nPat[i]) begin
                mRun[i]  = 1'b0;
                mDone[i] = 1'b1;
                mPass[i] = (mSig[i] == int'(golden[i]));
            end
        end
    endtask

    task automatic compareDut(input int i);
        logic       oReady, oBusy, oDone, oPass;
        logic [3:0] oSig;
        logic [3:0] oCnt;
        case (i)
            0: begin
                oReady = bus0.pat_ready; oBusy = bus0.busy; oDone = bus0.done;
                oPass = bus0.pass; oSig = bus0.signature; oCnt = {2'b00, bus0.pat_count};
            end
            1: begin
                oReady = bus1.pat_ready; oBusy = bus1.busy; oDone = bus1.done;
                oPass = bus1.pass; oSig = bus1.signature; oCnt = {2'b00, bus1.pat_count};
            end
            default: begin
                oReady = bus2.pat_ready; oBusy = bus2.busy; oDone = bus2.done;
                oPass = bus2.pass; oSig = bus2.signature; oCnt = bus2.pat_count;
            end
        endcase
        checkOutput($sformatf("dut%0d.pat_ready", i), 32'(oReady), 32'(mRun[i]));
        checkOutput($sformatf("dut%0d.busy", i),      32'(oBusy),  32'(mRun[i]));
        checkOutput($sformatf("dut%0d.done", i),      32'(oDone),  32'(mDone[i]));
        checkOutput($sformatf("dut%0d.pass", i),      32'(oPass),  32'(mPass[i]));
        checkOutput($sformatf("dut%0d.signature", i), 32'(oSig),   32'(mSig[i]));
        checkOutput($sformatf("dut%0d.pat_count", i), 32'(oCnt),   32'(mCnt[i]));
    endtask

    task automatic compareAll();
        for (int i = 0; i < 3; i++) compareDut(i);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare just after it.
    task automatic applyStimulus(input bit start, input bit valid, input logic [3:0] data);
        tbStart = start;
        tbValid = valid;
        tbData  = data;
        @(posedge clk);
        for (int i = 0; i < 3; i++) modelStep(i);
        #1;
        compareAll();
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic doReset();
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll();
        @(posedge clk);
        #4;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] lfsr;
        logic [3:0] words [15];
        int         expSig;

        nChecks   = 0;
        nFails    = 0;
        rst_n     = 1'b0;
        tbStart   = 1'b0;
        tbValid   = 1'b0;
        tbData    = 4'h0;
        golden[0] = 4'h4;
        golden[1] = 4'h0;
        golden[2] = 4'h0;
        modelReset();
        #2;
        compareAll();
        #10;
        rst_n = 1'b1;

        $display("[TB] three-word run 1,2,4 with golden 4");
        applyStimulus(1'b1, 1'b0, 4'h0);
        checkOutput("t2.busyAfterStart", 32'(bus0.busy), 32'd1);
        applyStimulus(1'b0, 1'b1, 4'h1);
        checkOutput("t2.sig1", 32'(bus0.signature), 32'h1);
        applyStimulus(1'b0, 1'b1, 4'h2);
        checkOutput("t2.sig2", 32'(bus0.signature), 32'h0);
        checkOutput("t2.notDoneYet", 32'(bus0.done), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'h4);
        checkOutput("t2.sig3", 32'(bus0.signature), 32'h4);
        checkOutput("t2.done", 32'(bus0.done), 32'd1);
        checkOutput("t2.pass", 32'(bus0.pass), 32'd1);

        $display("[TB] same run with golden 5");
        golden[0] = 4'h5;
        applyStimulus(1'b1, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b1, 4'h1);
        applyStimulus(1'b0, 1'b1, 4'h2);
        applyStimulus(1'b0, 1'b1, 4'h4);
        checkOutput("t2b.done", 32'(bus0.done), 32'd1);
        checkOutput("t2b.pass", 32'(bus0.pass), 32'd0);

        $display("[TB] feedback path F,0 on two-word unit");
        golden[1] = 4'hD;
        applyStimulus(1'b1, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b1, 4'hF);
        checkOutput("t3.sigF", 32'(bus1.signature), 32'hF);
        applyStimulus(1'b0, 1'b1, 4'h0);
        checkOutput("t3.sigD", 32'(bus1.signature), 32'hD);
        checkOutput("t3.done", 32'(bus1.done), 32'd1);
        checkOutput("t3.pass", 32'(bus1.pass), 32'd1);
        applyStimulus(1'b0, 1'b1, 4'h0);

        $display("[TB] gaps in pat_valid");
        golden[0] = 4'h4;
        applyStimulus(1'b1, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b1, 4'h1);
        checkOutput("t4.cnt1", 32'(bus0.pat_count), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'($urandom_range(0, 15)));
        checkOutput("t4.cntHold1", 32'(bus0.pat_count), 32'd1);
        applyStimulus(1'b0, 1'b0, 4'($urandom_range(0, 15)));
        checkOutput("t4.cntHold2", 32'(bus0.pat_count), 32'd1);
        applyStimulus(1'b0, 1'b1, 4'h2);
        checkOutput("t4.cnt2", 32'(bus0.pat_count), 32'd2);
        applyStimulus(1'b0, 1'b1, 4'h4);
        checkOutput("t4.sig", 32'(bus0.signature), 32'h4);
        checkOutput("t4.pass", 32'(bus0.pass), 32'd1);

        $display("[TB] start ignored in RUN, honoured in DONE");
        applyStimulus(1'b1, 1'b0, 4'h0);
        applyStimulus(1'b0, 1'b1, 4'h1);
        applyStimulus(1'b1, 1'b0, 4'h0);
        checkOutput("t5.noRestartCnt", 32'(bus0.pat_count), 32'd1);
        checkOutput("t5.noRestartSig", 32'(bus0.signature), 32'h1);
        applyStimulus(1'b0, 1'b1, 4'h2);
        applyStimulus(1'b0, 1'b1, 4'h4);
        checkOutput("t5.passBefore", 32'(bus0.pass), 32'd1);
        applyStimulus(1'b1, 1'b1, 4'h7);
        checkOutput("t5.doneCleared", 32'(bus0.done), 32'd0);
        checkOutput("t5.passCleared", 32'(bus0.pass), 32'd0);
        checkOutput("t5.sigSeed", 32'(bus0.signature), 32'h0);
        checkOutput("t5.cntZero", 32'(bus0.pat_count), 32'd0);
        applyStimulus(1'b0, 1'b1, 4'h3);

        $display("[TB] reset mid-run, then full-period lfsr run");
        doReset();
        lfsr   = 4'h1;
        expSig = 0;
        for (int k = 0; k < 15; k++) begin
            words[k] = lfsr;
            expSig   = misrNext(expSig, int'(lfsr));
            lfsr     = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
        end
        golden[2] = 4'(expSig);
        applyStimulus(1'b1, 1'b0, 4'h0);
        for (int k = 0; k < 15; k++) begin
            applyStimulus(1'b0, 1'b1, words[k]);
            if (k == 13) checkOutput("t6.notDone14", 32'(bus2.done), 32'd0);
        end
        checkOutput("t6.done", 32'(bus2.done), 32'd1);
        checkOutput("t6.pass", 32'(bus2.pass), 32'd1);
        checkOutput("t6.sig", 32'(bus2.signature), 32'(expSig));
        checkOutput("t6.cnt", 32'(bus2.pat_count), 32'd15);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++)
                if (!mRun[i] && $urandom_range(0, 3) == 0) golden[i] = 4'($urandom_range(0, 15));
            if (n == 200) doReset();
            applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
